// File: rtl/ft2_bus_arbiter_if.sv
// FT2232H async 245-FIFO pin bundle plus the word-level rx/tx handshakes.
// master: the arbiter side; slave: the environment (pins + DSO logic).
interface ft2_bus_arbiter_if;
   logic        rxf_n_in;
   logic        txe_n_in;
   logic [7:0]  d_in;
   logic [7:0]  d_out;
   logic        d_oe;
   logic        rd_n_out;
   logic        wr_n_out;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] tx_data;
   logic        tx_valid;
   logic        tx_ready;

   modport master (
      input  rxf_n_in, txe_n_in, d_in, rx_ready, tx_data, tx_valid,
      output d_out, d_oe, rd_n_out, wr_n_out, rx_data, rx_valid, tx_ready
   );

   modport slave (
      output rxf_n_in, txe_n_in, d_in, rx_ready, tx_data, tx_valid,
      input  d_out, d_oe, rd_n_out, wr_n_out, rx_data, rx_valid, tx_ready
   );
endinterface

// File: rtl/ft2_bus_arbiter.sv
// FT2232H 245-FIFO bus arbiter: assembles rx bytes into 32-bit words and
// serialises tx words, sharing the byte bus round-robin between directions.
// All pin outputs are registered from the next state, so strobes and the
// output enable change together and cannot glitch or overlap.
// Optional: define FT2_RX_PRIORITY_EN for fixed rx-over-tx priority.
//
// state    | meaning
// IDLE     | bus released, choose next direction
// RD_LOW   | RD# low for RD_PULSE cycles, byte sampled on last cycle
// RD_RECOV | RD# high for RD_RECOVER cycles before next access
// WR_SET   | d_oe/d_out driven for WR_SETUP cycles before WR# falls
// WR_LOW   | WR# low for WR_PULSE cycles, d_out held
// WR_HOLD  | WR# high, data still driven for 1 cycle
module ft2_bus_arbiter #(
   parameter int RD_PULSE   = 3,
   parameter int RD_RECOVER = 2,
   parameter int WR_SETUP   = 1,
   parameter int WR_PULSE   = 3
) (
   input  logic                clk,
   input  logic                rst,
   ft2_bus_arbiter_if.master   bus
);

   typedef enum logic [2:0] {
      IDLE, RD_LOW, RD_RECOV, WR_SET, WR_LOW, WR_HOLD
   } state_t;

   localparam logic [3:0] RD_PULSE_M1   = 4'(RD_PULSE - 1);
   localparam logic [3:0] RD_RECOVER_M1 = 4'(RD_RECOVER - 1);
   localparam logic [3:0] WR_SETUP_M1   = 4'(WR_SETUP - 1);
   localparam logic [3:0] WR_PULSE_M1   = 4'(WR_PULSE - 1);

   state_t      state, state_nxt;
   logic [3:0]  timer, timer_load;
   logic [1:0]  rx_cnt, tx_cnt;
   logic [31:0] tx_buf;
   logic [7:0]  tx_byte;
   logic        rx_elig, tx_elig;
   logic        rd_last;

`ifndef FT2_RX_PRIORITY_EN
   localparam logic GRANT_RX = 1'b0;
   localparam logic GRANT_TX = 1'b1;
   logic        last_grant, last_grant_nxt;
`endif

   assign rx_elig = !bus.rxf_n_in && !bus.rx_valid;
   assign tx_elig = !bus.txe_n_in && !bus.tx_ready;
   assign rd_last = (state == RD_LOW) && (timer == 4'd0);

   // Next-state selection and arbitration.
   always_comb begin
      state_nxt = state;
`ifndef FT2_RX_PRIORITY_EN
      last_grant_nxt = last_grant;
`endif
      case (state)
         IDLE: begin
`ifdef FT2_RX_PRIORITY_EN
            if (rx_elig)      state_nxt = RD_LOW;
            else if (tx_elig) state_nxt = WR_SET;
`else
            // Every grant updates last_grant so a tie always goes to the
            // direction served least recently.
            if (rx_elig && (!tx_elig || last_grant == GRANT_TX)) begin
               state_nxt      = RD_LOW;
               last_grant_nxt = GRANT_RX;
            end else if (tx_elig) begin
               state_nxt      = WR_SET;
               last_grant_nxt = GRANT_TX;
            end
`endif
         end
         RD_LOW:   if (timer == 4'd0) state_nxt = RD_RECOV;
         RD_RECOV: if (timer == 4'd0) state_nxt = IDLE;
         WR_SET:   if (timer == 4'd0) state_nxt = WR_LOW;
         WR_LOW:   if (timer == 4'd0) state_nxt = WR_HOLD;
         WR_HOLD:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Dwell time of the state being entered, minus one (timer counts to 0).
   always_comb begin
      timer_load = 4'd0;
      case (state_nxt)
         RD_LOW:   timer_load = RD_PULSE_M1;
         RD_RECOV: timer_load = RD_RECOVER_M1;
         WR_SET:   timer_load = WR_SETUP_M1;
         WR_LOW:   timer_load = WR_PULSE_M1;
         default:  timer_load = 4'd0;
      endcase
   end

   // Byte of the tx word currently due, first byte from [31:24].
   always_comb begin
      tx_byte = 8'h00;
      case (tx_cnt)
         2'd0: tx_byte = tx_buf[31:24];
         2'd1: tx_byte = tx_buf[23:16];
         2'd2: tx_byte = tx_buf[15:8];
         2'd3: tx_byte = tx_buf[7:0];
         default: tx_byte = 8'h00;
      endcase
   end

   // State register and dwell timer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         timer <= 4'd0;
`ifndef FT2_RX_PRIORITY_EN
         last_grant <= GRANT_TX;
`endif
      end else begin
         state <= state_nxt;
`ifndef FT2_RX_PRIORITY_EN
         last_grant <= last_grant_nxt;
`endif
         if (state_nxt != state) timer <= timer_load;
         else if (timer != 4'd0) timer <= timer - 4'd1;
      end
   end

   // Receive assembly and rx handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rx_data  <= 32'h0;
         bus.rx_valid <= 1'b0;
         rx_cnt       <= 2'd0;
      end else begin
         if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
         if (rd_last) begin
            case (rx_cnt)
               2'd0: bus.rx_data[31:24] <= bus.d_in;
               2'd1: bus.rx_data[23:16] <= bus.d_in;
               2'd2: bus.rx_data[15:8]  <= bus.d_in;
               2'd3: bus.rx_data[7:0]   <= bus.d_in;
               default: ;
            endcase
            rx_cnt <= rx_cnt + 2'd1;
            if (rx_cnt == 2'd3) bus.rx_valid <= 1'b1;
         end
      end
   end

   // Transmit buffer and tx handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_buf       <= 32'h0;
         tx_cnt       <= 2'd0;
         bus.tx_ready <= 1'b1;
      end else begin
         if (bus.tx_valid && bus.tx_ready) begin
            tx_buf       <= bus.tx_data;
            bus.tx_ready <= 1'b0;
         end
         if (state == WR_HOLD) begin
            tx_cnt <= tx_cnt + 2'd1;
            if (tx_cnt == 2'd3) bus.tx_ready <= 1'b1;
         end
      end
   end

   // Pin outputs registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.rd_n_out <= 1'b1;
         bus.wr_n_out <= 1'b1;
         bus.d_oe     <= 1'b0;
         bus.d_out    <= 8'h00;
      end else begin
         bus.rd_n_out <= (state_nxt != RD_LOW);
         bus.wr_n_out <= (state_nxt != WR_LOW);
         bus.d_oe     <= (state_nxt == WR_SET) || (state_nxt == WR_LOW) ||
                         (state_nxt == WR_HOLD);
         if (state_nxt == WR_SET) bus.d_out <= tx_byte;
      end
   end

endmodule

// File: tb/tb_ft2_bus_arbiter.sv
// Directed bench for ft2_bus_arbiter: receive, transmit, contention,
// backpressure, flag drop and reset in the middle of a write.
module tb_ft2_bus_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   viol = 0;
   int   ev_q[$];
   bit   rec_en = 1'b0;
   logic rd_prev = 1'b1;
   logic wr_prev = 1'b1;

   ft2_bus_arbiter_if bus();

   ft2_bus_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Bus invariants every cycle, and order of strobe falling edges.
   always @(negedge clk) begin
      if (bus.d_oe === 1'b1 && bus.rd_n_out === 1'b0) viol++;
      if (bus.rd_n_out === 1'b0 && bus.wr_n_out === 1'b0) viol++;
      if (rec_en && rd_prev === 1'b1 && bus.rd_n_out === 1'b0) ev_q.push_back(0);
      if (rec_en && wr_prev === 1'b1 && bus.wr_n_out === 1'b0) ev_q.push_back(1);
      rd_prev = bus.rd_n_out;
      wr_prev = bus.wr_n_out;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Waits for RD# low, drives the byte, counts the low cycles. Returns on
   // the first negedge with RD# high again (first recovery cycle).
   task automatic read_byte(input logic [7:0] b, input bit drop,
                            output int low_n, output int start_cyc);
      for (int i = 0; i < 60 && bus.rd_n_out !== 1'b0; i++) @(negedge clk);
      chk("rd_start", 32'(bus.rd_n_out), 0);
      start_cyc = cyc;
      bus.d_in = b;
      low_n = 0;
      while (bus.rd_n_out === 1'b0 && low_n < 40) begin
         low_n++;
         @(negedge clk);
         if (drop && low_n == 1) bus.rxf_n_in = 1'b1;
      end
   endtask

   // Waits for d_oe, then measures setup / WR# low / hold cycles. Returns
   // on the first negedge with d_oe low again.
   task automatic write_byte(output logic [7:0] b, output int setup_n,
                             output int low_n, output int hold_n);
      for (int i = 0; i < 60 && bus.d_oe !== 1'b1; i++) @(negedge clk);
      chk("wr_start", 32'(bus.d_oe), 1);
      b = bus.d_out;
      setup_n = 0;
      while (bus.d_oe === 1'b1 && bus.wr_n_out === 1'b1 && setup_n < 40) begin
         setup_n++;
         @(negedge clk);
      end
      low_n = 0;
      while (bus.wr_n_out === 1'b0 && low_n < 40) begin
         low_n++;
         @(negedge clk);
      end
      chk("wr_dout_stable", 32'(bus.d_out), 32'(b));
      hold_n = 0;
      while (bus.d_oe === 1'b1 && hold_n < 40) begin
         hold_n++;
         @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_tx(input logic [31:0] w);
      bus.tx_data  = w;
      bus.tx_valid = 1'b1;
      @(negedge clk);
      chk("tx_ready_drop", 32'(bus.tx_ready), 0);
      bus.tx_valid = 1'b0;
   endtask

   initial begin
      int          n, c0, c1, sn, ln, hn;
      logic [7:0]  b;
      logic [31:0] w;
      logic [31:0] rx_bytes;

      bus.rxf_n_in = 1'b1;
      bus.txe_n_in = 1'b1;
      bus.d_in     = 8'h00;
      bus.rx_ready = 1'b0;
      bus.tx_data  = 32'h0;
      bus.tx_valid = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_rd_n", 32'(bus.rd_n_out), 1);
      chk("rst_wr_n", 32'(bus.wr_n_out), 1);
      chk("rst_d_oe", 32'(bus.d_oe), 0);
      chk("rst_d_out", 32'(bus.d_out), 0);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 0);
      chk("rst_tx_ready", 32'(bus.tx_ready), 1);
      rst = 1'b0;
      @(negedge clk);

      // Receive a word
      rx_bytes = 32'h11223344;
      bus.rxf_n_in = 1'b0;
      c0 = 0;
      for (int i = 0; i < 4; i++) begin
         read_byte(rx_bytes[31 - 8*i -: 8], 1'b0, n, c1);
         chk("rx_low_cycles", 32'(n), 3);
         if (i == 1) chk("rx_byte_period", 32'(c1 - c0), 6);
         c0 = c1;
      end
      chk("rx_valid_word", 32'(bus.rx_valid), 1);
      chk("rx_data_word", bus.rx_data, 32'h11223344);

      // Backpressure: no read while rx_valid stays high
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rd_n_out === 1'b0) n++;
      end
      chk("bp_no_read", 32'(n), 0);
      chk("bp_valid_held", 32'(bus.rx_valid), 1);
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
      chk("bp_valid_drop", 32'(bus.rx_valid), 0);

      // Reads resume; rxf_n rises on the 2nd low cycle of this strobe
      read_byte(8'h55, 1'b1, n, c1);
      chk("drop_low_cycles", 32'(n), 3);
      chk("drop_byte_stored", bus.rx_data, 32'h55223344);
      chk("drop_partial_not_valid", 32'(bus.rx_valid), 0);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.rd_n_out === 1'b0) n++;
      end
      chk("drop_no_read", 32'(n), 0);
      bus.rxf_n_in = 1'b0;
      read_byte(8'h66, 1'b0, n, c1);
      bus.rxf_n_in = 1'b1;
      chk("partial_continues", bus.rx_data, 32'h55663344);

      // Transmit a word
      pulse_reset();
      chk("rst_discards_rx", bus.rx_data, 0);
      bus.txe_n_in = 1'b0;
      w = 32'hA1B2C3D4;
      load_tx(w);
      for (int i = 0; i < 4; i++) begin
         write_byte(b, sn, ln, hn);
         chk("tx_byte", 32'(b), 32'(w[31 - 8*i -: 8]));
         chk("tx_setup_cycles", 32'(sn), 1);
         chk("tx_wr_low_cycles", 32'(ln), 3);
         chk("tx_hold_cycles", 32'(hn), 1);
         chk("tx_ready_after_byte", 32'(bus.tx_ready), (i == 3) ? 1 : 0);
      end
      bus.txe_n_in = 1'b1;

      // Contention: alternate RD, WR starting with RD after reset
      pulse_reset();
      bus.rx_ready = 1'b1;
      load_tx(32'h0A0B0C0D);
      bus.d_in = 8'h77;
      ev_q.delete();
      rec_en = 1'b1;
      bus.rxf_n_in = 1'b0;
      bus.txe_n_in = 1'b0;
      repeat (60) @(negedge clk);
      bus.rxf_n_in = 1'b1;
      bus.txe_n_in = 1'b1;
      rec_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("cont_event_count", 32'(ev_q.size() >= 8), 1);
      for (int i = 0; i < 8 && i < ev_q.size(); i++)
         chk("cont_order", 32'(ev_q[i]), 32'(i % 2));
      chk("cont_rx_word", bus.rx_data, 32'h77777777);
      chk("cont_tx_done", 32'(bus.tx_ready), 1);
      bus.rx_ready = 1'b0;

      // Reset in the middle of the second write strobe
      pulse_reset();
      bus.txe_n_in = 1'b0;
      load_tx(32'hDEADBEEF);
      write_byte(b, sn, ln, hn);
      chk("rmw_first_byte", 32'(b), 32'hDE);
      for (int i = 0; i < 60 && bus.wr_n_out !== 1'b0; i++) @(negedge clk);
      chk("rmw_wr_low", 32'(bus.wr_n_out), 0);
      #2 rst = 1'b1;
      #1;
      chk("rmw_wr_n_release", 32'(bus.wr_n_out), 1);
      chk("rmw_d_oe_release", 32'(bus.d_oe), 0);
      chk("rmw_tx_ready", 32'(bus.tx_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      w = 32'h01020304;
      load_tx(w);
      for (int i = 0; i < 4; i++) begin
         write_byte(b, sn, ln, hn);
         chk("rmw_new_byte", 32'(b), 32'(w[31 - 8*i -: 8]));
      end
      chk("rmw_tx_ready_end", 32'(bus.tx_ready), 1);
      bus.txe_n_in = 1'b1;

      chk("invariant_violations", 32'(viol), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ft2_bus_arbiter.md
Name: ft2_bus_arbiter

Overview:
Controller for the FT2232H async 245-FIFO byte bus, shared between a receive path and a transmit path.
- Receive: reads bytes into 32-bit words.
- Transmit: serialises 32-bit words onto the bus.
- Arbitration: round-robin between directions.
- Timing: generates RD#/WR# strobes and bus output-enable with programmable pulse widths, so bus contention cannot occur.
- Position: sits between the FT2232H pins and the DSO command/sample logic.

Parameters:
RD_PULSE, 3, cycles RD# held low; data sampled on the final low cycle (1..15)
RD_RECOVER, 2, cycles RD# held high after a read before returning to IDLE (1..15)
WR_SETUP, 1, cycles d_oe/d_out driven before WR# falls (1..15)
WR_PULSE, 3, cycles WR# held low (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
rxf_n_in  in  1  FT2232H RXF#, low = byte available
txe_n_in  in  1  FT2232H TXE#, low = space available
d_in  in  8  bus input
d_out  out  8  bus output byte
d_oe  out  1  bus tristate enable, 1 = drive d_out
rd_n_out  out  1  FT2232H RD#
wr_n_out  out  1  FT2232H WR#
rx_data  out  32  assembled word, first byte in [31:24]
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
tx_data  in  32  word to send; [31:24] is sent first
tx_valid  in  1  tx_data valid
tx_ready  out  1  tx buffer empty, can accept a word

Behaviour:
- Outputs: all registered, so strobes are glitch-free.
- Reset values: rd_n_out=1, wr_n_out=1, d_oe=0, d_out=0, rx_data=0, rx_valid=0, tx_ready=1.
- Reset internals: state=IDLE, byte counters=0, last_grant=TX (RX wins the first tie).
- States: IDLE, RD_LOW, RD_RECOV, WR_SET, WR_LOW, WR_HOLD. A 4-bit timer loads on each state entry.
- Eligibility:
  - rx_elig = !rxf_n_in & !rx_valid.
  - tx_elig = !txe_n_in & tx buffer loaded.
- IDLE:
  - Only rx_elig → RD_LOW.
  - Only tx_elig → WR_SET.
  - Both → grant the direction opposite last_grant; update last_grant.
  - Neither → stay.
- RD_LOW: rd_n_out=0 for RD_PULSE cycles.
  - On the last cycle, d_in is written to rx byte slot rx_cnt (0→[31:24] … 3→[7:0]) and rx_cnt increments.
  - → RD_RECOV.
- RD_RECOV: rd_n_out=1 for RD_RECOVER cycles, then → IDLE.
  - If rx_cnt wrapped 3→0, rx_valid=1 on the first RD_RECOV cycle.
- WR_SET: d_oe=1, d_out = tx byte tx_cnt, for WR_SETUP cycles.
- WR_LOW: wr_n_out=0 for WR_PULSE cycles; d_out stable.
- WR_HOLD: wr_n_out=1, d_oe=1 for 1 cycle; tx_cnt increments; → IDLE, where d_oe=0.
  - If tx_cnt wrapped 3→0, the tx buffer empties and tx_ready=1 on the IDLE cycle.
- Per-byte cost at defaults: 6 clk for rx (3+2+1) and 6 clk for tx (1+3+1+1).
- Invariants:
  - d_oe=1 never coincides with rd_n_out=0.
  - rd_n_out and wr_n_out are never low together.
- Handshakes:
  - TX: a word is accepted on clk with tx_valid & tx_ready; tx_ready drops the next cycle.
  - RX: the word transfers on rx_valid & rx_ready; rx_valid drops the next cycle.
  - While rx_valid=1, no new read starts. A grant already in progress completes.
- Flag changes mid-strobe: rxf_n_in or txe_n_in deasserting mid-strobe does not abort it; the byte transfer completes.
- Partial words: a partial RX word waits indefinitely for its remaining bytes. There is no timeout.
- Reset mid-operation: strobes release immediately (asynchronous). Partial rx/tx words are discarded; counters return to 0.

Optional Feature:
FT2_RX_PRIORITY_EN
- Defined: fixed priority; rx_elig always wins over tx_elig, and last_grant is unused.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Receive word: rxf_n_in=0 continuously, d_in = 0x11, 0x22, 0x33, 0x44 per strobe → rx_data=0x11223344 and rx_valid=1 on the 4th RD_RECOV entry. rd_n_out low 3 clk per byte, 6 clk byte period.
- Transmit word: txe_n_in=0, tx_data=0xA1B2C3D4 pulsed with tx_valid → bytes A1, B2, C3, D4 out in that order. d_oe rises 1 clk before wr_n_out falls; wr_n low 3 clk; tx_ready=1 after the 4th byte.
- Contention: both directions eligible for 8 bytes → strobes alternate RD, WR, RD, WR, starting with RD after reset. No cycle has d_oe=1 & rd_n_out=0.
- Backpressure: rx_ready=0 after a full word → no RD# pulse while rx_valid=1. Raising rx_ready for 1 clk → rx_valid=0 next clk, then reads resume.
- Flag drop: rxf_n_in rises on the 2nd RD_LOW cycle → pulse still lasts 3 clk and the byte is stored. No further read until rxf_n_in=0.
- Reset mid-write: assert rst during WR_LOW of byte 2 → wr_n_out=1, d_oe=0, tx_ready=1 immediately. After release, a new word 0x01020304 is sent starting at byte 0x01.
